// File: rtl/bus_arbiter_if.sv
// Shared-bus signal bundle between the two masters, the arbiter and the two
// slaves. The arbiter uses the `slave` view: it serves the masters'
// requests and drives the slave-side bus. The `master` view is the
// opposite side, used by whatever drives requests and slave read data.
interface bus_arbiter_if;
    // Master 0 (CPU side)
    logic        m0_req;
    logic        m0_wr;
    logic [7:0]  m0_address;
    logic [31:0] m0_dout;
    // Master 1 (factorial master)
    logic        m1_req;
    logic        m1_wr;
    logic [7:0]  m1_address;
    logic [31:0] m1_dout;
    // Arbiter responses to the masters
    logic        m0_grant;
    logic        m1_grant;
    logic [31:0] m_din;
    // Shared slave bus
    logic [7:0]  s_address;
    logic        s_wr;
    logic [31:0] s_dout;
    logic        s0_sel;
    logic        s1_sel;
    logic [31:0] s0_din;
    logic [31:0] s1_din;

    modport slave (
        input  m0_req, m0_wr, m0_address, m0_dout,
        input  m1_req, m1_wr, m1_address, m1_dout,
        input  s0_din, s1_din,
        output m0_grant, m1_grant, m_din,
        output s_address, s_wr, s_dout, s0_sel, s1_sel
    );

    modport master (
        output m0_req, m0_wr, m0_address, m0_dout,
        output m1_req, m1_wr, m1_address, m1_dout,
        output s0_din, s1_din,
        input  m0_grant, m1_grant, m_din,
        input  s_address, s_wr, s_dout, s0_sel, s1_sel
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master / two-slave shared-bus arbiter with address decode.
// The owner keeps the bus while it requests; on release the bus passes
// straight to the other requester, giving round-robin under contention.
// Read data returns one cycle after the address via a registered select.
module bus_arbiter #(
    parameter logic [2:0] S0_BASE = 3'b000,
    parameter logic [2:0] S1_BASE = 3'b001
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10,
        BAD  = 2'b11
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  rd_sel_q, rd_sel_d;

    logic [7:0]  s_address;
    logic        s_wr;
    logic [31:0] s_dout;
    logic        s0_sel;
    logic        s1_sel;
    logic [31:0] m_din;
    logic        grant_active;

    // Next-state: current owner holds, otherwise hand to the other requester.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_d unassigned (no latch).
        state_d = IDLE;
        case (state_q)
            IDLE: begin
                if (bus.m0_req)      state_d = GNT0;
                else if (bus.m1_req) state_d = GNT1;
            end
            GNT0: begin
                if (bus.m0_req)      state_d = GNT0;
                else if (bus.m1_req) state_d = GNT1;
            end
            GNT1: begin
                if (bus.m1_req)      state_d = GNT1;
                else if (bus.m0_req) state_d = GNT0;
            end
            default: state_d = IDLE;  // illegal encoding recovers to IDLE
        endcase
    end

    // Master mux, address decode, read-select capture and read-data return.
    always_comb begin
        s_address    = 8'h00;
        s_wr         = 1'b0;
        s_dout       = 32'h0;
        grant_active = 1'b0;
        if (state_q == GNT0) begin
            s_address    = bus.m0_address;
            s_wr         = bus.m0_wr;
            s_dout       = bus.m0_dout;
            grant_active = 1'b1;
        end else if (state_q == GNT1) begin
            s_address    = bus.m1_address;
            s_wr         = bus.m1_wr;
            s_dout       = bus.m1_dout;
            grant_active = 1'b1;
        end

        // Unmapped regions select nothing, so writes there are dropped
        // and reads return zero.
        s0_sel   = grant_active && (s_address[7:5] == S0_BASE);
        s1_sel   = grant_active && (s_address[7:5] == S1_BASE);
        rd_sel_d = {s1_sel, s0_sel} & ~{2{s_wr}};

        if (rd_sel_q[0])      m_din = bus.s0_din;
        else if (rd_sel_q[1]) m_din = bus.s1_din;
        else                  m_din = 32'h0;
    end

    // State and read-select registers; reset overrides all requests.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q  <= IDLE;
            rd_sel_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    assign bus.m0_grant  = (state_q == GNT0);
    assign bus.m1_grant  = (state_q == GNT1);
    assign bus.m_din     = m_din;
    assign bus.s_address = s_address;
    assign bus.s_wr      = s_wr;
    assign bus.s_dout    = s_dout;
    assign bus.s0_sel    = s0_sel;
    assign bus.s1_sel    = s1_sel;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed steps followed by random
// traffic, compared every cycle against an owner/pending-read model.
module tb_bus_arbiter;

    logic clk;
    logic reset;

    bus_arbiter_if bif ();

    bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Model: who owns the bus (-1 none), and which slave a read issued
    // last cycle is waiting on (-1 none or unmapped).
    int owner = -1;
    int pend  = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_addr();
        if (owner == 0) return bif.m0_address;
        if (owner == 1) return bif.m1_address;
        return 8'h00;
    endfunction

    function automatic logic model_wr();
        if (owner == 0) return bif.m0_wr;
        if (owner == 1) return bif.m1_wr;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_dout();
        if (owner == 0) return bif.m0_dout;
        if (owner == 1) return bif.m1_dout;
        return 32'h0;
    endfunction

    function automatic logic req_of(input int m);
        return (m == 0) ? bif.m0_req : bif.m1_req;
    endfunction

    // Compare every DUT output against the model.
    task automatic check_all();
        logic [7:0]  ea;
        int          region;
        logic [31:0] em;
        ea     = model_addr();
        region = int'(ea[7:5]);
        em     = (pend == 0) ? bif.s0_din : (pend == 1) ? bif.s1_din : 32'h0;
        check("m0_grant",  32'(bif.m0_grant),  32'(owner == 0));
        check("m1_grant",  32'(bif.m1_grant),  32'(owner == 1));
        check("s_address", 32'(bif.s_address), 32'(ea));
        check("s_wr",      32'(bif.s_wr),      32'(model_wr()));
        check("s_dout",    bif.s_dout,         model_dout());
        check("s0_sel",    32'(bif.s0_sel),    32'(owner != -1 && region == 0));
        check("s1_sel",    32'(bif.s1_sel),    32'(owner != -1 && region == 1));
        check("m_din",     bif.m_din,          em);
    endtask

    // Advance the model across one rising edge using the inputs held there.
    task automatic model_step();
        int region;
        int first;
        if (reset) begin
            owner = -1;
            pend  = -1;
        end else begin
            region = int'(model_addr() >> 5);
            pend   = (owner != -1 && !model_wr() && region < 2) ? region : -1;
            if (owner == -1 || !req_of(owner)) begin
                first = (owner == -1) ? 0 : 1 - owner;
                if (req_of(first))          owner = first;
                else if (req_of(1 - first)) owner = 1 - first;
                else                        owner = -1;
            end
        end
    endtask

    // One clock: check mid-cycle, then step the model at the edge.
    task automatic cycle();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        // Reset held two edges with both masters requesting.
        reset          = 1'b1;
        bif.m0_req     = 1'b1;
        bif.m0_wr      = 1'b0;
        bif.m0_address = 8'h00;
        bif.m0_dout    = 32'h0;
        bif.m1_req     = 1'b1;
        bif.m1_wr      = 1'b0;
        bif.m1_address = 8'h00;
        bif.m1_dout    = 32'h0;
        bif.s0_din     = 32'h1111_1111;
        bif.s1_din     = 32'h2222_2222;
        @(posedge clk);
        model_step();
        #1;
        cycle();
        check("rst_m0_grant", 32'(bif.m0_grant), 32'h0);
        check("rst_m1_grant", 32'(bif.m1_grant), 32'h0);
        check("rst_m_din",    bif.m_din,         32'h0);
        check("rst_s_wr",     32'(bif.s_wr),     32'h0);

        // Release: master 0 wins the simultaneous request.
        reset = 1'b0;
        cycle();
        check("rel_m0_grant", 32'(bif.m0_grant), 32'h1);
        check("rel_m1_grant", 32'(bif.m1_grant), 32'h0);
        cycle();
        cycle();
        cycle();

        // Master 0 drops: direct handoff to master 1, no idle bubble.
        bif.m0_req = 1'b0;
        cycle();
        check("ho_m1_grant", 32'(bif.m1_grant), 32'h1);
        check("ho_m0_grant", 32'(bif.m0_grant), 32'h0);

        // Write routing from master 1 to slave 1.
        bif.m1_wr      = 1'b1;
        bif.m1_address = 8'h21;
        bif.m1_dout    = 32'h0000_0078;
        #1;
        check("wr_s1_sel",    32'(bif.s1_sel),    32'h1);
        check("wr_s0_sel",    32'(bif.s0_sel),    32'h0);
        check("wr_s_wr",      32'(bif.s_wr),      32'h1);
        check("wr_s_address", 32'(bif.s_address), 32'h21);
        check("wr_s_dout",    bif.s_dout,         32'h78);
        cycle();

        // Hand back to master 0 and read slave 0, then slave 1.
        bif.m1_req     = 1'b0;
        bif.m1_wr      = 1'b0;
        bif.m0_req     = 1'b1;
        bif.m0_wr      = 1'b0;
        bif.m0_address = 8'h03;
        cycle();
        cycle();
        bif.s0_din = 32'h0000_0018;
        #1;
        check("rd_s0_m_din", bif.m_din, 32'h18);
        bif.m0_address = 8'h25;
        bif.s1_din     = 32'hDEAD_BEEF;
        cycle();
        check("rd_s1_m_din", bif.m_din, 32'hDEAD_BEEF);

        // Unmapped read returns zero next cycle.
        bif.m0_address = 8'h80;
        #1;
        check("um_s0_sel", 32'(bif.s0_sel), 32'h0);
        check("um_s1_sel", 32'(bif.s1_sel), 32'h0);
        cycle();
        check("um_m_din", bif.m_din, 32'h0);

        // No requests: bus idles with zeros.
        bif.m0_req  = 1'b0;
        bif.m0_dout = 32'hCAFE_0001;
        cycle();
        check("idle_s_address", 32'(bif.s_address), 32'h0);
        check("idle_s_dout",    bif.s_dout,         32'h0);

        // Reset in the middle of a master 1 write tenure.
        bif.m1_req     = 1'b1;
        bif.m1_wr      = 1'b1;
        bif.m1_address = 8'h20;
        bif.m1_dout    = 32'h0000_0005;
        cycle();
        check("mt_m1_grant", 32'(bif.m1_grant), 32'h1);
        check("mt_s_wr",     32'(bif.s_wr),     32'h1);
        reset = 1'b1;
        cycle();
        check("mtr_m1_grant", 32'(bif.m1_grant), 32'h0);
        check("mtr_s_wr",     32'(bif.s_wr),     32'h0);
        reset = 1'b0;
        cycle();
        check("mtrel_m1_grant", 32'(bif.m1_grant), 32'h1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0) bif.m0_req = ~bif.m0_req;
            if ($urandom_range(0, 3) == 0) bif.m1_req = ~bif.m1_req;
            bif.m0_wr      = 1'($urandom_range(0, 1));
            bif.m1_wr      = 1'($urandom_range(0, 1));
            bif.m0_address = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(64, 255))
                                                         : 8'($urandom_range(0, 63));
            bif.m1_address = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(64, 255))
                                                         : 8'($urandom_range(0, 63));
            bif.m0_dout    = $urandom;
            bif.m1_dout    = $urandom;
            bif.s0_din     = $urandom;
            bif.s1_din     = $urandom;
            cycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
